// File: rtl/neuron.sv
// Streaming fully-connected neuron: saturating MAC over numWeight inputs, bias add, sigmoid/ReLU activation.
// Weights and bias are loaded over the config bus.
module neuron #(
  parameter int numWeight      = 784,
  parameter int layerNo        = 1,
  parameter int neuronNo       = 0,
  parameter int dataWidth      = 8,
  parameter int sigmoidSize    = 10,
  parameter int weightIntWidth = 4,
  parameter     actType        = "sigmoid",
  parameter     weightFile     = "w_1_0.mif",
  parameter     biasFile       = "b_1_0.mif"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [dataWidth-1:0]   myinput,
  input  logic                   myinputValid,
  input  logic                   weightValid,
  input  logic                   biasValid,
  input  logic [31:0]            weightValue,
  input  logic [31:0]            biasValue,
  input  logic [31:0]            config_layer_num,
  input  logic [31:0]            config_neuron_num,
  output logic [2*dataWidth-1:0] sum_o,
  output logic [dataWidth-1:0]   out,
  output logic                   outvalid
);

  localparam int SW = 2 * dataWidth;
  localparam int AW = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(numWeight - 1);

  logic [dataWidth-1:0] wmem [numWeight];
  logic [SW-1:0]        bias_mem [1];
  logic [AW-1:0]        waddr;
  logic [AW-1:0]        raddr;
  logic                 cfg_hit;
  logic                 w_wr;
  logic                 b_wr;

  logic                        v0, v1;
  logic                        first0, first1;
  logic                        last0, last1;
  logic                        bias_go, act_go, out_go;
  logic signed [dataWidth-1:0] in_r;
  logic signed [dataWidth-1:0] w_r;
  logic signed [SW-1:0]        mul_r;
  logic [dataWidth-1:0]        act_r;
  logic [dataWidth-1:0]        act_next;

  logic unused_bits;
  assign unused_bits = ^{weightValue[31:dataWidth], biasValue[31:SW],
                         weightFile != 0, biasFile != 0,
                         sigmoidSize > 0, weightIntWidth > 0};

  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] s;
    s = a + b;
    if (!a[SW-1] && !b[SW-1] && s[SW-1])
      s = {1'b0, {(SW-1){1'b1}}};
    else if (a[SW-1] && b[SW-1] && !s[SW-1])
      s = {1'b1, {(SW-1){1'b0}}};
    return s;
  endfunction

  assign cfg_hit = (config_layer_num == 32'(layerNo)) && (config_neuron_num == 32'(neuronNo));
  assign w_wr    = weightValid && cfg_hit;
  assign b_wr    = biasValid && cfg_hit;

  // Storage is deliberately outside reset so a reset does not wipe loaded weights.
  always_ff @(posedge clk) begin
    if (w_wr) wmem[waddr] <= weightValue[dataWidth-1:0];
    if (b_wr) bias_mem[0] <= biasValue[SW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) waddr <= '0;
    else if (w_wr) waddr <= (waddr == LAST_ADDR) ? '0 : waddr + 1'b1;
  end

  // Valid/first/last tags travel with each sample so input gaps simply stall nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raddr    <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      first0   <= 1'b0;
      first1   <= 1'b0;
      last0    <= 1'b0;
      last1    <= 1'b0;
      bias_go  <= 1'b0;
      act_go   <= 1'b0;
      out_go   <= 1'b0;
      in_r     <= '0;
      w_r      <= '0;
      mul_r    <= '0;
      act_r    <= '0;
      sum_o    <= '0;
      out      <= '0;
      outvalid <= 1'b0;
    end else begin
      v0 <= myinputValid;
      if (myinputValid) begin
        in_r   <= myinput;
        w_r    <= wmem[raddr];
        first0 <= (raddr == '0);
        last0  <= (raddr == LAST_ADDR);
        raddr  <= (raddr == LAST_ADDR) ? '0 : raddr + 1'b1;
      end

      v1 <= v0;
      if (v0) begin
        mul_r  <= in_r * w_r;
        first1 <= first0;
        last1  <= last0;
      end

      bias_go <= v1 && last1;
      if (v1) sum_o <= first1 ? mul_r : sat_add(sum_o, mul_r);
      else if (bias_go) sum_o <= sat_add(sum_o, bias_mem[0]);

      act_go <= bias_go;
      if (act_go) act_r <= act_next;

      out_go <= act_go;
      if (out_go) begin
        out      <= act_r;
        outvalid <= 1'b1;
      end else if (myinputValid && raddr == '0) begin
        outvalid <= 1'b0;
      end
    end
  end

  generate
    if (actType == "relu") begin : g_relu
      always_comb begin
        act_next = sum_o[SW-1-weightIntWidth -: dataWidth];
        if (sum_o[SW-1])
          act_next = '0;
        else if (|sum_o[SW-2:SW-weightIntWidth])
          act_next = {1'b0, {(dataWidth-1){1'b1}}};
      end
    end else begin : g_sigmoid
      logic [dataWidth-1:0]   sig_rom [2**sigmoidSize];
      logic [sigmoidSize-1:0] sig_addr;
      initial begin
        for (int i = 0; i < 2**sigmoidSize; i++) begin
          real x;
          real y;
          int  q;
          x = real'(i - 2**(sigmoidSize-1)) / (2.0 ** (sigmoidSize - 1 - weightIntWidth));
          y = 1.0 / (1.0 + $exp(-x));
          q = int'(y * (2.0 ** dataWidth));
          if (q > 2**dataWidth - 1) q = 2**dataWidth - 1;
          if (q < 0) q = 0;
          sig_rom[i] = dataWidth'(q);
        end
      end
      // Signed sum becomes an offset-binary ROM index.
      assign sig_addr = {~sum_o[SW-1], sum_o[SW-2 -: sigmoidSize-1]};
      assign act_next = sig_rom[sig_addr];
    end
  endgenerate

endmodule

// File: tb/tb_neuron.sv
// Directed bench for neuron (numWeight=4, ReLU): config bus, MAC, saturation, latency, hold and reset abort.
module tb_neuron;

  logic        clk;
  logic        rst;
  logic [7:0]  myinput;
  logic        myinputValid;
  logic        weightValid;
  logic        biasValid;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic [15:0] sum_o;
  logic [7:0]  out;
  logic        outvalid;

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];

  neuron #(
    .numWeight(4), .layerNo(1), .neuronNo(0), .dataWidth(8),
    .sigmoidSize(10), .weightIntWidth(4), .actType("relu")
  ) dut (
    .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
    .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .sum_o(sum_o), .out(out), .outvalid(outvalid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_weights(input int layer, input int neuron_n, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      config_layer_num  = layer;
      config_neuron_num = neuron_n;
      weightValue       = {24'h0, w[8*i +: 8]};
      weightValid       = 1'b1;
    end
    @(negedge clk);
    weightValid = 1'b0;
  endtask

  task automatic load_bias(input int layer, input int neuron_n, input logic [15:0] b);
    @(negedge clk);
    config_layer_num  = layer;
    config_neuron_num = neuron_n;
    biasValue         = {16'h0, b};
    biasValid         = 1'b1;
    @(negedge clk);
    biasValid = 1'b0;
  endtask

  // ins holds input i in byte i; gap idle cycles are inserted between inputs.
  task automatic run_frame(input string tag, input logic [31:0] ins, input int gap,
                           input logic [15:0] exp_sum, input logic [7:0] exp_out);
    int k;
    logic [23:0] e;
    exp_q.push_back({exp_sum, exp_out});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) check({tag, " outvalid drop"}, {31'h0, outvalid}, 32'h0);
      myinput      = ins[8*i +: 8];
      myinputValid = 1'b1;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          myinputValid = 1'b0;
        end
      end
    end
    @(negedge clk);
    myinputValid = 1'b0;
    k = 0;
    while (!outvalid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, 5);
    e = exp_q.pop_front();
    if (outvalid) begin
      check({tag, " sum_o"}, {16'h0, sum_o}, {16'h0, e[23:8]});
      check({tag, " out"}, {24'h0, out}, {24'h0, e[7:0]});
    end
  endtask

  initial begin
    rst = 1'b0;
    myinput = '0; myinputValid = 1'b0;
    weightValid = 1'b0; biasValid = 1'b0;
    weightValue = '0; biasValue = '0;
    config_layer_num = '0; config_neuron_num = '0;
    repeat (2) @(negedge clk);
    check("reset sum_o", {16'h0, sum_o}, 32'h0);
    check("reset out", {24'h0, out}, 32'h0);
    check("reset outvalid", {31'h0, outvalid}, 32'h0);
    rst = 1'b1;

    load_weights(1, 0, 32'h04030201);
    load_bias(1, 0, 16'h0000);
    run_frame("ones", 32'h01010101, 0, 16'h000A, 8'h00);
    repeat (3) @(negedge clk);
    check("hold outvalid", {31'h0, outvalid}, 32'h1);
    check("hold sum_o", {16'h0, sum_o}, 32'h000A);

    // Strobes for other neurons/layers must not touch this neuron.
    load_weights(1, 1, 32'h09090909);
    load_weights(2, 0, 32'h09090909);
    load_bias(1, 1, 16'h1000);
    run_frame("mismatch", 32'h01010101, 0, 16'h000A, 8'h00);

    load_bias(1, 0, 16'h0010);
    run_frame("mixed", 32'h0503FF02, 0, 16'h002D, 8'h02);
    run_frame("gaps", 32'h0503FF02, 2, 16'h002D, 8'h02);

    load_bias(1, 0, 16'hFF00);
    run_frame("relu neg", 32'h00000000, 0, 16'hFF00, 8'h00);
    load_bias(1, 0, 16'h0050);
    run_frame("relu slice", 32'h00000000, 1, 16'h0050, 8'h05);
    load_bias(1, 0, 16'h1000);
    run_frame("relu sat", 32'h00000000, 0, 16'h1000, 8'h7F);

    load_weights(1, 0, 32'h7F7F7F7F);
    load_bias(1, 0, 16'h0005);
    run_frame("acc sat pos", 32'h7F7F7F7F, 0, 16'h7FFF, 8'h7F);
    load_bias(1, 0, 16'h1000);
    run_frame("bias sat pos", 32'h00007F7F, 0, 16'h7FFF, 8'h7F);

    load_weights(1, 0, 32'h81818181);
    load_bias(1, 0, 16'hFFFB);
    run_frame("acc sat neg", 32'h7F7F7F7F, 0, 16'h8000, 8'h00);
    load_bias(1, 0, 16'hF000);
    run_frame("bias sat neg", 32'h00007F7F, 0, 16'h8000, 8'h00);

    // Abort a frame with pipeline stages in flight.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      myinput = 8'h01; myinputValid = 1'b1;
    end
    @(negedge clk);
    myinputValid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort sum_o", {16'h0, sum_o}, 32'h0);
    check("abort outvalid", {31'h0, outvalid}, 32'h0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort no outvalid", {31'h0, outvalid}, 32'h0);
    run_frame("after abort", 32'h01010101, 0, 16'hEE04, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
